// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Two requesters share one combinational ALU. Each requester has a
//   valid/ready request channel carrying (a, b, op) and a valid/ready response
//   channel carrying (res, flags). Only one operation is in flight at a time.
//   Operands are registered on accept, and results are registered at the end
//   of EXEC. A response is presented in RESP until the owner takes it.
//
//   FSM: IDLE -> EXEC (any request) -> RESP -> IDLE (owner rsp_ready).
//   IDLE is always visited between operations.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   reqN_valid/ready    request handshake for requester N (N = 0, 1)
//   reqN_a/b/op         operands and ALU op code (0 = add)
//   rspN_valid/ready    response handshake for requester N
//   rspN_res/flags      registered result and flags {N,Z,C,V}; both channels
//                       carry the same result registers
//   busy                high in EXEC or RESP
//
// Configuration
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie, and no
//                          last-served pointer is kept. Requester 1 can starve.
//                          undefined: round-robin on ties.
// -----------------------------------------------------------------------------

// Combinational ALU: flags = {N, Z, C, V}
module alu_arbiter_alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        flags_o
);
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              c, v;

  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_i)
      OP_W'(0): begin // add
        sum = {1'b0, a_i} + {1'b0, b_i};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (res[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_W'(1): begin // sub as a + ~b + 1; C = no borrow
        sum = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (res[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_W'(2): res = a_i & b_i;
      OP_W'(3): res = a_i | b_i;
      OP_W'(4): res = a_i ^ b_i;
      OP_W'(5): res = a_i << b_i[SH_W-1:0];
      OP_W'(6): res = a_i >> b_i[SH_W-1:0];
      OP_W'(7): res = DATA_W'($signed(a_i) >>> b_i[SH_W-1:0]);
      OP_W'(8): res = b_i;
      default:  res = '0;
    endcase
  end

  assign res_o   = res;
  assign flags_o = {res[DATA_W-1], (res == '0), c, v};
endmodule

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_res,
  output logic [FLAG_W-1:0] rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_res,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              own_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] res_q;
  logic [FLAG_W-1:0] flags_q;
  logic              gnt0, gnt1;
  logic              accept;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;

  // Grant is evaluated every cycle and qualified with IDLE at the ready outputs.
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid & ~req0_valid;
`else
  logic last_q; // requester served most recently; reset to 1 so 0 wins the first tie
  assign gnt0 = req0_valid & (~req1_valid |  last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= req1_ready;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0_valid | req1_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (own_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready = (state_q == IDLE) & gnt0;
    req1_ready = (state_q == IDLE) & gnt1;
    rsp0_valid = (state_q == RESP) & ~own_q;
    rsp1_valid = (state_q == RESP) &  own_q;
    busy       = (state_q != IDLE);
  end

  assign accept = req0_ready | req1_ready;

  // Operand capture on accept, result capture at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        own_q <= req1_ready;
        a_q   <= req1_ready ? req1_a  : req0_a;
        b_q   <= req1_ready ? req1_b  : req0_b;
        op_q  <= req1_ready ? req1_op : req0_op;
      end
      if (state_q == EXEC) begin
        res_q   <= alu_res;
        flags_q <= alu_flags;
      end
    end
  end

  alu_arbiter_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  assign rsp0_res   = res_q;
  assign rsp0_flags = flags_q;
  assign rsp1_res   = res_q;
  assign rsp1_flags = flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_res, rsp1_res;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic        busy;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_flags(rsp1_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference add: {res, N, Z, C, V}
  function automatic logic [35:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = s[31:0];
    return {r, r[31], (r == 32'd0), s[32], (a[31] == b[31]) && (r[31] != a[31])};
  endfunction

  // Scoreboard
  logic [35:0] q0[$], q1[$];
  int          gq[$];
  int          inflight = 0;
  logic [31:0] last_res[2];
  logic [3:0]  last_flags[2];

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot", req0_ready & req1_ready, 0);
      check("rspv_onehot", rsp0_valid & rsp1_valid, 0);
      // accepts first, so an accept in the cycle RESP exits is caught
      if (req0_valid && req0_ready) begin
        check("acc0_inflight", inflight, 0);
        q0.push_back(model_add(req0_a, req0_b)); gq.push_back(0); inflight++;
      end
      if (req1_valid && req1_ready) begin
        check("acc1_inflight", inflight, 0);
        q1.push_back(model_add(req1_a, req1_b)); gq.push_back(1); inflight++;
      end
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", 1, 0);
        else begin
          logic [35:0] e;
          e = q0.pop_front();
          check("rsp0_res", rsp0_res, e[35:4]);
          check("rsp0_flags", rsp0_flags, e[3:0]);
        end
        last_res[0] = rsp0_res; last_flags[0] = rsp0_flags; inflight--;
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) check("rsp1_unexpected", 1, 0);
        else begin
          logic [35:0] e;
          e = q1.pop_front();
          check("rsp1_res", rsp1_res, e[35:4]);
          check("rsp1_flags", rsp1_flags, e[3:0]);
        end
        last_res[1] = rsp1_res; last_flags[1] = rsp1_flags; inflight--;
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_op = 4'd0; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_op = 4'd0; end
  endtask

  // Present a request and wait (bounded) for it to be accepted; w = cycles waited.
  task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int w);
    bit got = 0;
    w = 0;
    @(posedge clk); #1;
    set_req(n, 1'b1, a, b);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin got = 1; break; end
      w++;
    end
    if (!got) check($sformatf("req%0d_timeout", n), 0, 1);
    if (!hold || !got) begin
      @(posedge clk); #1;
      set_req(n, 1'b0, a, b);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    int w, w0, w1;
    int exp_g[4];
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1; // early ready must be ignored outside RESP

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_res", rsp0_res, 0);
    check("rst_flags", rsp1_flags, 0);
    rst = 0;

    // Single request: 2 + 3
    do_req(0, 32'd2, 32'd3, 0, w);
    check("t1_first_cycle", w, 0);
    @(negedge clk);
    check("t1_exec_rsp0_valid", rsp0_valid, 0);
    check("t1_exec_busy", busy, 1);
    @(negedge clk);
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_res", rsp0_res, 5);
    check("t1_flags", rsp0_flags, 4'b0000);
    check("t1_rsp1_valid", rsp1_valid, 0);
    wait_idle();

    // Zero/carry on requester 1
    do_req(1, 32'd11, -32'sd11, 0, w);
    @(negedge clk);
    @(negedge clk);
    check("t2_rsp1_valid", rsp1_valid, 1);
    check("t2_rsp0_valid", rsp0_valid, 0);
    check("t2_res", rsp1_res, 0);
    check("t2_flags", rsp1_flags, 4'b0110);
    wait_idle();

    // Tie: last served is 1, so requester 0 goes first
    gq.delete();
    fork
      do_req(0, -32'sd32, -32'sd7, 0, w0);
      do_req(1, 32'h7fff_fff5, 32'd11, 0, w1);
    join
    wait_idle();
    check("t3_grants", gq.size(), 2);
    if (gq.size() == 2) begin
      check("t3_first", gq[0], 0);
      check("t3_second", gq[1], 1);
    end
    check("t3_res0", last_res[0], 32'hffff_ffd9);
    check("t3_flags0", last_flags[0], 4'b1010);
    check("t3_res1", last_res[1], 32'h8000_0000);
    check("t3_flags1", last_flags[1], 4'b1001);

    // Response backpressure with requester 1 waiting
    rsp0_ready = 0;
    do_req(0, 32'd5, 32'd7, 0, w);
    for (int i = 0; i < 10 && !rsp0_valid; i++) @(negedge clk);
    fork
      do_req(1, 32'd1, 32'd1, 0, w1);
      begin
        for (int i = 0; i < 5; i++) begin
          check("t4_hold_valid", rsp0_valid, 1);
          check("t4_hold_res", rsp0_res, 12);
          check("t4_hold_flags", rsp0_flags, 0);
          check("t4_hold_busy", busy, 1);
          check("t4_hold_req1_ready", req1_ready, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        rsp0_ready = 1;
      end
    join
    wait_idle();
    check("t4_res1", last_res[1], 2);

    // Async reset in EXEC discards the operation
    do_req(0, 32'd9, 32'd9, 0, w);
    #3;
    rst = 1;
    q0.delete(); q1.delete(); inflight = 0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_rsp0_valid", rsp0_valid, 0);
    check("t5_req0_ready", req0_ready, 0);
    check("t5_res", rsp0_res, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rsp", rsp0_valid | rsp1_valid, 0);
    end
    do_req(0, 32'd100, 32'd23, 0, w);
    wait_idle();
    check("t5_after", last_res[0], 123);

    // A few random single requests
    for (int i = 0; i < 6; i++) begin
      do_req(i % 2, $urandom, $urandom, 0, w);
      wait_idle();
    end

    // Back-to-back with both valid; last served is 1 here
    do_req(1, 32'd4, 32'd4, 0, w);
    wait_idle();
    gq.delete();
    fork
      begin
        do_req(0, $urandom, $urandom, 1, w0);
        do_req(0, $urandom, $urandom, 0, w0);
      end
      begin
        do_req(1, $urandom, $urandom, 1, w1);
        do_req(1, $urandom, $urandom, 0, w1);
      end
    join
    wait_idle();
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    check("t6_grants", gq.size(), 4);
    if (gq.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("t6_grant%0d", i), gq[i], exp_g[i]);
    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
